// File: rtl/cordic_arbiter.sv
// Round-robin front end that shares one CORDIC vectoring pipeline between NREQ requesters.
// Tags ride a shift register that advances with the CORDIC enable; results leave through one output register.
module cordic_arbiter #(
    parameter int N    = 10,
    parameter int NREQ = 3,
    parameter int LAT  = 13,
    parameter int IDW  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*N-1:0]      i_req_x,
    input  logic [NREQ*N-1:0]      i_req_y,
    output logic [NREQ-1:0]        o_req_ready,
    output logic signed [N-1:0]    o_cordic_x,
    output logic signed [N-1:0]    o_cordic_y,
    output logic                   o_cordic_en,
    input  logic signed [8:0]      i_cordic_angle,
    output logic                   o_res_valid,
    output logic [IDW-1:0]         o_res_id,
    output logic signed [8:0]      o_res_angle,
    input  logic                   i_res_ready,
    output logic                   o_busy
);

    logic [LAT-1:0]     vld_q, vld_d;
    logic [IDW-1:0]     id_q [LAT];
    logic [IDW-1:0]     id_d [LAT];
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic               res_valid_q, res_valid_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic signed [8:0]  res_angle_q, res_angle_d;

    logic               stall;
    logic               found;
    logic               grant;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     cand;
    logic [IDW:0]       sum;

    // Arbitration: first valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        stall   = res_valid_q & ~i_res_ready & vld_q[LAT-1];
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!found && i_req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        grant       = found & ~stall;
        sel         = grant ? gnt_idx : '0;
        o_req_ready = '0;
        if (grant) begin
            o_req_ready[gnt_idx] = 1'b1;
        end
        o_cordic_x = i_req_x[N-1:0];
        o_cordic_y = i_req_y[N-1:0];
        for (int k = 1; k < NREQ; k++) begin
            if (sel == IDW'(k)) begin
                o_cordic_x = i_req_x[k*N +: N];
                o_cordic_y = i_req_y[k*N +: N];
            end
        end
        o_cordic_en = ~stall;
    end

    // Tag pipe moves in lockstep with the CORDIC; the output register pops and pushes in one cycle.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        ptr_d = ptr_q;
        if (!stall) begin
            vld_d   = {vld_q[LAT-2:0], grant};
            id_d[0] = gnt_idx;
            for (int k = 1; k < LAT; k++) begin
                id_d[k] = id_q[k-1];
            end
        end
        if (grant) begin
            ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_angle_d = res_angle_q;
        if (!res_valid_q || i_res_ready) begin
            res_valid_d = vld_q[LAT-1];
            res_id_d    = id_q[LAT-1];
            res_angle_d = i_cordic_angle;
        end
    end

    always_ff @(posedge i_clk) begin
        id_q <= id_d;
        if (!i_rst_n) begin
            vld_q       <= '0;
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_angle_q <= '0;
        end else begin
            vld_q       <= vld_d;
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_angle_q <= res_angle_d;
        end
    end

    assign o_res_valid = res_valid_q;
    assign o_res_id    = res_id_q;
    assign o_res_angle = res_angle_q;
    assign o_busy      = (|vld_q) | res_valid_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: behavioural CORDIC stand-in, queue-based reference model,
// directed vector table, multi-cycle corner sequences and a randomized run.
module tb_cordic_arbiter;
    localparam int N    = 10;
    localparam int NREQ = 3;
    localparam int LAT  = 13;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic signed [N-1:0]  rx [NREQ];
    logic signed [N-1:0]  ry [NREQ];
    logic [NREQ*N-1:0]    req_x, req_y;
    logic [NREQ-1:0]      req_ready;
    logic signed [N-1:0]  cx, cy;
    logic                 cen;
    logic signed [8:0]    cangle;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic signed [8:0]    res_angle;
    logic                 res_ready = 1'b1;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NREQ; k++) begin : g_pack
        assign req_x[k*N +: N] = rx[k];
        assign req_y[k*N +: N] = ry[k];
    end

    cordic_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_x(req_x), .i_req_y(req_y),
        .o_req_ready(req_ready),
        .o_cordic_x(cx), .o_cordic_y(cy), .o_cordic_en(cen),
        .i_cordic_angle(cangle),
        .o_res_valid(res_valid), .o_res_id(res_id), .o_res_angle(res_angle),
        .i_res_ready(res_ready), .o_busy(busy)
    );

    function automatic int ang(input int x, input int y);
        real r;
        r = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural CORDIC: LAT enabled register stages from operand capture to angle.
    logic signed [8:0] cpipe [LAT];
    initial for (int k = 0; k < LAT; k++) cpipe[k] = '0;
    always @(posedge clk) begin
        if (cen) begin
            for (int k = LAT-1; k > 0; k--) cpipe[k] <= cpipe[k-1];
            cpipe[0] <= 9'(ang(int'(cx), int'(cy)));
        end
    end
    assign cangle = cpipe[LAT-1];

    // Reference model: in-flight queue with per-item age, one optional output slot.
    typedef struct { int id; int angle; int age; } fl_t;
    fl_t infl [$];
    int  m_ptr = 0;
    bit  m_ov  = 1'b0;
    int  m_oid = 0, m_oang = 0;
    bit  mon_on = 1'b0;
    logic [NREQ-1:0] rdy_seen = '0;
    int  n_grant = 0, n_dlv = 0;
    bit  head_rdy, m_stall;
    int  g;

    always @(negedge clk) begin
        if (mon_on) begin
            head_rdy = (infl.size() > 0) && (infl[0].age == LAT);
            m_stall  = m_ov && !res_ready && head_rdy;
            g = -1;
            if (!m_stall) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
                end
            end
            chk("mdl_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
            chk("mdl_en", int'(cen), m_stall ? 0 : 1);
            chk("mdl_res_valid", int'(res_valid), int'(m_ov));
            chk("mdl_busy", int'(busy), (infl.size() > 0 || m_ov) ? 1 : 0);
            if (m_ov) begin
                chk("mdl_res_id", int'(res_id), m_oid);
                chk("mdl_res_angle", int'(res_angle), m_oang);
            end
            rdy_seen = req_ready;
            if (res_valid && res_ready) n_dlv++;
            if (!rst_n) begin
                infl.delete();
                m_ov  = 1'b0;
                m_ptr = 0;
            end else begin
                if (!m_ov || res_ready) begin
                    if (head_rdy) begin
                        m_ov   = 1'b1;
                        m_oid  = infl[0].id;
                        m_oang = infl[0].angle;
                        void'(infl.pop_front());
                    end else begin
                        m_ov = 1'b0;
                    end
                end
                if (!m_stall) begin
                    foreach (infl[i]) infl[i].age++;
                    if (g >= 0) begin
                        infl.push_back('{g, ang(int'(rx[g]), int'(ry[g])), 1});
                        m_ptr = (g + 1) % NREQ;
                        n_grant++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        n_grant = 0;
        n_dlv = 0;
    endtask

    // Retire outstanding requests without withdrawing any that has not been accepted.
    task automatic serve(input int bound);
        int c;
        c = 0;
        while (req_valid != '0 && c < bound) begin
            tick();
            req_valid = req_valid & ~rdy_seen;
            c++;
        end
        if (req_valid != '0) chk("serve_timeout", int'(req_valid), 0);
    endtask

    typedef struct { int k; int x; int y; int id; int angle; } vec_t;
    vec_t vt [6];

    initial begin
        int c, lat;
        vt[0] = '{0,  200,  200, 0,   45};
        vt[1] = '{1,    0, -200, 1,  -90};
        vt[2] = '{2, -200,    0, 2,  180};
        vt[3] = '{1,  100,    0, 1,    0};
        vt[4] = '{2,    0,  150, 2,   90};
        vt[5] = '{0, -100, -100, 0, -135};
        for (int k = 0; k < NREQ; k++) begin rx[k] = '0; ry[k] = '0; end

        tick();
        tick();
        rst_n = 1'b1;
        mon_on = 1'b1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_angle", int'(res_angle), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(cen), 1);

        // Idle: nothing requested for 30 cycles
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("idle_res_valid", int'(res_valid), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_en", int'(cen), 1);
        end

        // Single-request vectors: latency, id and angle
        for (int v = 0; v < 6; v++) begin
            rx[vt[v].k] = N'(vt[v].x);
            ry[vt[v].k] = N'(vt[v].y);
            req_valid = NREQ'(1 << vt[v].k);
            c = 0;
            do begin tick(); c++; end while (!rdy_seen[vt[v].k] && c < 20);
            chk("vec_accept", int'(rdy_seen[vt[v].k]), 1);
            req_valid = '0;
            lat = 0;
            do begin tick(); lat++; end while (!res_valid && lat < 40);
            chk("vec_latency", lat, LAT);
            chk("vec_id", int'(res_id), vt[v].id);
            chk("vec_angle", int'(res_angle), vt[v].angle);
            tick();
        end

        // All three requesting continuously: round-robin 0,1,2,0,1,2
        do_reset();
        rx[0] = 10'sd200;  ry[0] = 10'sd200;
        rx[1] = 10'sd0;    ry[1] = -10'sd200;
        rx[2] = -10'sd200; ry[2] = 10'sd0;
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_grant", int'(rdy_seen), 1 << (i % 3));
        end
        req_valid = '0;
        c = 0;
        while (!res_valid && c < 30) begin tick(); c++; end
        for (int i = 0; i < 6; i++) begin
            chk("rr_res_valid", int'(res_valid), 1);
            chk("rr_res_id", int'(res_id), i % 3);
            tick();
        end
        chk("rr_res_after", int'(res_valid), 0);

        // Full pipe with consumer backpressure for 5 cycles
        do_reset();
        req_valid = '1;
        repeat (20) tick();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_en", int'(cen), 0);
            chk("stall_ready", int'(req_ready), 0);
            tick();
        end
        res_ready = 1'b1;
        serve(20);
        repeat (40) tick();
        chk("stall_count", n_dlv, n_grant);
        chk("stall_busy", int'(busy), 0);

        // Reset six cycles after four accepts drops everything in flight
        do_reset();
        req_valid = '1;
        tick(); chk("rst4_g0", int'(rdy_seen), 1);
        tick(); chk("rst4_g1", int'(rdy_seen), 2); req_valid = 3'b101;
        tick(); chk("rst4_g2", int'(rdy_seen), 4); req_valid = 3'b001;
        tick(); chk("rst4_g3", int'(rdy_seen), 1); req_valid = '0;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_grant = 0;
        n_dlv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rst4_res_valid", int'(res_valid), 0);
            chk("rst4_busy", int'(busy), 0);
        end
        req_valid = '1;
        tick();
        chk("rst4_ptr", int'(rdy_seen), 1);
        req_valid = req_valid & ~rdy_seen;
        serve(10);
        repeat (20) tick();

        // Randomized traffic and backpressure
        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick();
            res_ready = ($urandom % 10) < 7;
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] || rdy_seen[k]) begin
                    req_valid[k] = 1'($urandom % 2);
                    rx[k] = N'($urandom);
                    ry[k] = N'($urandom);
                end
            end
        end
        serve(20);
        res_ready = 1'b1;
        repeat (40) tick();
        chk("rand_count", n_dlv, n_grant);
        chk("rand_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
